// File: rtl/train_seq_ctrl_if.sv
// Handshake bundle between the training sequencer and its host/datapath/memories.
// TRAIN_ERR_STOP_EN adds the err_ok early-stop input.
interface train_seq_ctrl_if #(
    parameter int ADDR_W  = 10,
    parameter int EPOCH_W = 8
);
    logic               start;
    logic               sample_done;
`ifdef TRAIN_ERR_STOP_EN
    logic               err_ok;
`endif
    logic               din;
    logic               select_initial;
    logic [ADDR_W-1:0]  addr;
    logic               update_en;
    logic [EPOCH_W-1:0] epoch;
    logic               busy;
    logic               done;

`ifdef TRAIN_ERR_STOP_EN
    modport master (output start, sample_done, err_ok,
                    input  din, select_initial, addr, update_en, epoch, busy, done);
    modport slave  (input  start, sample_done, err_ok,
                    output din, select_initial, addr, update_en, epoch, busy, done);
`else
    modport master (output start, sample_done,
                    input  din, select_initial, addr, update_en, epoch, busy, done);
    modport slave  (input  start, sample_done,
                    output din, select_initial, addr, update_en, epoch, busy, done);
`endif
endinterface

// File: rtl/train_seq_ctrl.sv
// Training-run sequencer: initial parameter load, then fetch/wait/update per sample over all epochs.
// Optional TRAIN_ERR_STOP_EN: err_ok at an epoch wrap ends the run early.
//
// state  | meaning
// IDLE   | waiting for start after reset
// INIT   | select_initial held for INIT_CYCLES cycles
// FETCH  | one-cycle sample read (din) at addr
// WAIT   | datapath running forward/backward pass
// UPDATE | one-cycle weight update, advance addr/epoch
// DONE   | run finished, waiting for restart
module train_seq_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int N_SAMPLES   = 1000,
    parameter int EPOCH_W     = 8,
    parameter int N_EPOCHS    = 100,
    parameter int INIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             res,
    train_seq_ctrl_if.slave  bus
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_INIT   = 3'd1;
    localparam logic [2:0] S_FETCH  = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [EPOCH_W-1:0] LAST_EPOCH = EPOCH_W'(N_EPOCHS - 1);
    localparam int                 INIT_W     = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [INIT_W-1:0]  INIT_LOAD  = INIT_W'(INIT_CYCLES - 1);

    logic [2:0]         state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [EPOCH_W-1:0] epoch_q, epoch_d;
    logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
    logic               din_q, sel_q, upd_q, busy_q, done_q;
    logic               stop_early;

`ifdef TRAIN_ERR_STOP_EN
    assign stop_early = bus.err_ok;
`else
    assign stop_early = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        epoch_d    = epoch_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    state_d    = S_INIT;
                    addr_d     = '0;
                    epoch_d    = '0;
                    init_cnt_d = INIT_LOAD;
                end
            end
            S_INIT: begin
                if (init_cnt_q == '0) begin
                    state_d = S_FETCH;
                end else begin
                    init_cnt_d = init_cnt_q - 1'b1;
                end
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (bus.sample_done) begin
                    state_d = S_UPDATE;
                end
            end
            S_UPDATE: begin
                if (addr_q != LAST_ADDR) begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    // Epoch wrap: epoch stays at the finished index when the run ends here.
                    addr_d = '0;
                    if ((epoch_q == LAST_EPOCH) || stop_early) begin
                        state_d = S_DONE;
                    end else begin
                        epoch_d = epoch_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            epoch_q    <= '0;
            init_cnt_q <= '0;
            din_q      <= 1'b0;
            sel_q      <= 1'b0;
            upd_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            epoch_q    <= epoch_d;
            init_cnt_q <= init_cnt_d;
            din_q      <= (state_d == S_FETCH);
            sel_q      <= (state_d == S_INIT);
            upd_q      <= (state_d == S_UPDATE);
            busy_q     <= (state_d == S_INIT) || (state_d == S_FETCH) ||
                          (state_d == S_WAIT) || (state_d == S_UPDATE);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign bus.din            = din_q;
    assign bus.select_initial = sel_q;
    assign bus.addr           = addr_q;
    assign bus.update_en      = upd_q;
    assign bus.epoch          = epoch_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;

endmodule

// File: tb/tb_train_seq_ctrl.sv
// Directed bench for train_seq_ctrl with N_SAMPLES=4, N_EPOCHS=2, INIT_CYCLES=2.
// Early-stop scenario runs only when TRAIN_ERR_STOP_EN is defined.
module tb_train_seq_ctrl;

    localparam int ADDR_W  = 10;
    localparam int EPOCH_W = 8;

    logic clk = 1'b0;
    logic res = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   cnt_din, cnt_upd, cnt_busy;

    train_seq_ctrl_if #(.ADDR_W(ADDR_W), .EPOCH_W(EPOCH_W)) bus ();

    train_seq_ctrl #(
        .ADDR_W(ADDR_W), .N_SAMPLES(4), .EPOCH_W(EPOCH_W), .N_EPOCHS(2), .INIT_CYCLES(2)
    ) dut (
        .clk(clk),
        .res(res),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Tallies the cycle just observed, then advances to the next falling edge.
    task automatic step();
        if (bus.din === 1'b1) cnt_din++;
        if (bus.update_en === 1'b1) cnt_upd++;
        if (bus.busy === 1'b1) cnt_busy++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_din"},  32'(bus.din), 0);
        chk({tag, "_sel"},  32'(bus.select_initial), 0);
        chk({tag, "_upd"},  32'(bus.update_en), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    // One run from IDLE/DONE. wc = WAIT cycles per sample; sample_done asserted in the last one.
    task automatic do_run(input int wc, input bit noise, input bit tied, input int n_samp,
                          input int abort_s, input bit err_mode);
        logic sd_idle;
        sd_idle = tied;
        cnt_din = 0; cnt_upd = 0; cnt_busy = 0;
        bus.sample_done = sd_idle;
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("init_sel",  32'(bus.select_initial), 1);
            chk("init_busy", 32'(bus.busy), 1);
            chk("init_done", 32'(bus.done), 0);
            chk("init_din",  32'(bus.din), 0);
            step();
        end
        for (int s = 0; s < n_samp; s++) begin
            chk("fetch_din",   32'(bus.din), 1);
            chk("fetch_addr",  32'(bus.addr), 32'(s % 4));
            chk("fetch_epoch", 32'(bus.epoch), 32'(s / 4));
            chk("fetch_sel",   32'(bus.select_initial), 0);
            chk("fetch_upd",   32'(bus.update_en), 0);
            if (noise) begin
                bus.start = 1'b1;
                bus.sample_done = 1'b1;
            end
            step();
            bus.start = 1'b0;
            bus.sample_done = sd_idle;
            for (int w = 0; w < wc; w++) begin
                chk("wait_din",  32'(bus.din), 0);
                chk("wait_upd",  32'(bus.update_en), 0);
                chk("wait_busy", 32'(bus.busy), 1);
                if (s == abort_s) begin
                    chk("pre_rst_epoch", 32'(bus.epoch), 1);
                    chk("pre_rst_addr",  32'(bus.addr), 2);
                    res = 1'b1;
                    #1;
                    chk_quiet("async_rst");
                    chk("async_rst_addr",  32'(bus.addr), 0);
                    chk("async_rst_epoch", 32'(bus.epoch), 0);
                    chk("async_rst_done",  32'(bus.done), 0);
                    #1 res = 1'b0;
                    @(negedge clk);
                    bus.sample_done = 1'b1;
                    step();
                    bus.sample_done = 1'b0;
                    step();
                    chk_quiet("post_rst");
                    chk("post_rst_done", 32'(bus.done), 0);
                    return;
                end
                if (w == wc - 1) bus.sample_done = 1'b1;
                else if (noise && w == 0) bus.start = 1'b1;
                step();
                bus.sample_done = sd_idle;
                bus.start = 1'b0;
            end
            chk("upd_en",    32'(bus.update_en), 1);
            chk("upd_din",   32'(bus.din), 0);
            chk("upd_epoch", 32'(bus.epoch), 32'(s / 4));
            if (noise) bus.sample_done = 1'b1;
`ifdef TRAIN_ERR_STOP_EN
            if (err_mode && (s == 1 || s == 3)) bus.err_ok = 1'b1;
`endif
            step();
            bus.sample_done = sd_idle;
`ifdef TRAIN_ERR_STOP_EN
            bus.err_ok = 1'b0;
`endif
        end
        chk("end_done",  32'(bus.done), 1);
        chk("end_busy",  32'(bus.busy), 0);
        chk("end_upd",   32'(bus.update_en), 0);
        chk("end_din",   32'(bus.din), 0);
        chk("end_epoch", 32'(bus.epoch), err_mode ? 0 : 1);
        chk("cnt_din",   32'(cnt_din), 32'(n_samp));
        chk("cnt_upd",   32'(cnt_upd), 32'(n_samp));
        chk("cnt_busy",  32'(cnt_busy), 32'(2 + n_samp * (wc + 2)));
        step();
        chk("held_done",  32'(bus.done), 1);
        chk("held_epoch", 32'(bus.epoch), err_mode ? 0 : 1);
        bus.sample_done = 1'b0;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.sample_done = 1'b0;
`ifdef TRAIN_ERR_STOP_EN
        bus.err_ok = 1'b0;
`endif
        @(negedge clk);
        chk_quiet("reset");
        chk("reset_done",  32'(bus.done), 0);
        chk("reset_addr",  32'(bus.addr), 0);
        chk("reset_epoch", 32'(bus.epoch), 0);
        res = 1'b0;
        step();
        chk_quiet("idle");

        // Basic run: sample_done three cycles after each din.
        do_run(3, 1'b0, 1'b0, 8, -1, 1'b0);
        // Restart from DONE with sample_done tied high: 3-cycle sample period, 26 busy cycles.
        do_run(1, 1'b0, 1'b1, 8, -1, 1'b0);
        // Asynchronous reset while waiting on epoch 1, addr 2.
        do_run(3, 1'b0, 1'b0, 8, 6, 1'b0);
        do_run(3, 1'b0, 1'b0, 8, -1, 1'b0);
        // Stray start/sample_done pulses outside the states that honour them.
        do_run(3, 1'b1, 1'b0, 8, -1, 1'b0);
`ifdef TRAIN_ERR_STOP_EN
        // err_ok ignored at a non-wrap update, stops the run at the first wrap.
        do_run(2, 1'b0, 1'b0, 4, -1, 1'b1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
